// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Raster timing generator for a 640x480@60 VGA output driven from a 50 MHz
//   system clock. A toggle register divides the clock down to a 25 MHz pixel
//   tick. Horizontal/vertical counters advance once per pixel tick, and all
//   decoded outputs (syncs, active video, result-image window flag and its
//   linear read address) are registered from the next counter values so
//   they never lag the counters.
//
// Ports:
//   clk            in   1   system clock (50 MHz)
//   rst_n          in   1   asynchronous active-low reset
//   H_Count_Value  out  10  horizontal pixel position, 0..H_TOTAL-1
//   V_Count_Value  out  10  line position, 0..V_TOTAL-1
//   hsync          out  1   horizontal sync, active low
//   vsync          out  1   vertical sync, active low
//   video_on       out  1   inside the visible 640x480 area
//   pix_tick       out  1   high in the clk cycle before each pixel advance
//   frame_start    out  1   one-clk pulse on the advance into (0,0)
//   win_valid      out  1   inside the WIN_W x WIN_H result-image window
//   win_addr       out  19  linear address of the pixel inside the window
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned WIN_W    = 480,
    parameter int unsigned WIN_H    = 320
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [9:0]  H_Count_Value,
    output logic [9:0]  V_Count_Value,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        pix_tick,
    output logic        frame_start,
    output logic        win_valid,
    output logic [18:0] win_addr
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] WIN_W_L    = 10'(WIN_W);
    localparam logic [9:0] WIN_H_L    = 10'(WIN_H);

    logic        t_q;
    logic [9:0]  hCount_q;
    logic [9:0]  vCount_q;
    logic [9:0]  hCount_d;
    logic [9:0]  vCount_d;
    logic        hsync_q;
    logic        vsync_q;
    logic        videoOn_q;
    logic        frameStart_q;
    logic        winValid_q;
    logic [18:0] winAddr_q;
    logic        frameWrap;
    logic        inWinNext;

    // Next raster position. Decoding from these values (rather than the
    // current ones) is what keeps the registered outputs aligned with the
    // counters on the very edge the counters move.
    always_comb begin
        hCount_d = hCount_q + 10'd1;
        vCount_d = vCount_q;
        if (hCount_q == H_MAX) begin
            hCount_d = '0;
            if (vCount_q == V_MAX) begin
                vCount_d = '0;
            end else begin
                vCount_d = vCount_q + 10'd1;
            end
        end
        frameWrap = (hCount_d == '0) && (vCount_d == '0);
        inWinNext = (hCount_d < WIN_W_L) && (vCount_d < WIN_H_L);
    end

    // The divider toggles every clk; a clk edge with t_q high is an advance
    // edge. frame_start is evaluated on every edge so it self-clears on the
    // following non-advance edge.
    //
    // win_addr is a plain up-counter over in-window pixels: the value held
    // outside the window is the last in-window address, so the first pixel
    // of the next window line is simply that value plus one, which equals
    // V*WIN_W with no multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q          <= 1'b0;
            hCount_q     <= H_MAX;
            vCount_q     <= V_MAX;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            videoOn_q    <= 1'b0;
            frameStart_q <= 1'b0;
            winValid_q   <= 1'b0;
            winAddr_q    <= '0;
        end else begin
            t_q          <= ~t_q;
            frameStart_q <= t_q & frameWrap;
            if (t_q) begin
                hCount_q   <= hCount_d;
                vCount_q   <= vCount_d;
                hsync_q    <= !((hCount_d >= HS_FIRST) && (hCount_d <= HS_LAST));
                vsync_q    <= !((vCount_d >= VS_FIRST) && (vCount_d <= VS_LAST));
                videoOn_q  <= (hCount_d < H_VIS) && (vCount_d < V_VIS);
                winValid_q <= inWinNext;
                if (frameWrap) begin
                    winAddr_q <= '0;
                end else if (inWinNext) begin
                    winAddr_q <= winAddr_q + 19'd1;
                end
            end
        end
    end

    assign H_Count_Value = hCount_q;
    assign V_Count_Value = vCount_q;
    assign hsync         = hsync_q;
    assign vsync         = vsync_q;
    assign video_on      = videoOn_q;
    assign pix_tick      = t_q;
    assign frame_start   = frameStart_q;
    assign win_valid     = winValid_q;
    assign win_addr      = winAddr_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Drives two copies of vga_timing_gen from one clock and reset: dutD uses
// the real 640x480 timing, dutS uses a shrunken raster (32x19 total,
// 14x9 window) so whole frames, vsync and frame wrap fit in a short run.
// Expected outputs come from a closed-form model: the number of clk edges
// since reset release gives the number of pixel advances, which maps
// directly to a raster position and from there to every output.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    // Small-raster geometry
    localparam int S_HA = 20, S_HFP = 3, S_HS = 4, S_HBP = 5;
    localparam int S_VA = 12, S_VFP = 2, S_VS = 2, S_VBP = 3;
    localparam int S_WW = 14, S_WH = 9;
    localparam int S_FRAME_CLK = (S_HA + S_HFP + S_HS + S_HBP) * (S_VA + S_VFP + S_VS + S_VBP) * 2;

    logic clk;
    logic rst_n;

    logic [9:0]  hD, vD, hS, vS;
    logic        hsD, vsD, voD, ptD, fsD, wvD;
    logic        hsS, vsS, voS, ptS, fsS, wvS;
    logic [18:0] waD, waS;

    logic [44:0] obsD, obsS;
    logic [44:0] expV;

    int vectors;
    int miscompares;
    int k;

    vga_timing_gen dutD (
        .clk           (clk),
        .rst_n         (rst_n),
        .H_Count_Value (hD),
        .V_Count_Value (vD),
        .hsync         (hsD),
        .vsync         (vsD),
        .video_on      (voD),
        .pix_tick      (ptD),
        .frame_start   (fsD),
        .win_valid     (wvD),
        .win_addr      (waD)
    );

    vga_timing_gen #(
        .H_ACTIVE (S_HA), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP),
        .V_ACTIVE (S_VA), .V_FP (S_VFP), .V_SYNC (S_VS), .V_BP (S_VBP),
        .WIN_W    (S_WW), .WIN_H (S_WH)
    ) dutS (
        .clk           (clk),
        .rst_n         (rst_n),
        .H_Count_Value (hS),
        .V_Count_Value (vS),
        .hsync         (hsS),
        .vsync         (vsS),
        .video_on      (voS),
        .pix_tick      (ptS),
        .frame_start   (fsS),
        .win_valid     (wvS),
        .win_addr      (waS)
    );

    assign obsD = {hD, vD, hsD, vsD, voD, ptD, fsD, wvD, waD};
    assign obsS = {hS, vS, hsS, vsS, voS, ptS, fsS, wvS, waS};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges seen since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    // Expected output bundle after 'edges' clk edges out of reset, packed
    // in the same order as obsD/obsS.
    function automatic logic [44:0] model(input int edges,
                                          input int ha, input int hfp, input int hs, input int hbp,
                                          input int va, input int vfp, input int vs, input int vbp,
                                          input int ww, input int wh);
        int ht, vt, adv, pos, h, v, addr;
        logic hsy, vsy, vid, pix, fs, win;
        ht  = ha + hfp + hs + hbp;
        vt  = va + vfp + vs + vbp;
        adv = edges / 2;
        pix = (edges % 2) == 1;
        if (adv == 0) begin
            h = ht - 1; v = vt - 1; addr = 0; fs = 1'b0;
        end else begin
            pos = (adv - 1) % (ht * vt);
            h   = pos % ht;
            v   = pos / ht;
            fs  = ((edges % 2) == 0) && (pos == 0);
            if (v < wh) addr = (h < ww) ? v * ww + h : v * ww + ww - 1;
            else        addr = wh * ww - 1;
        end
        hsy = !((h >= ha + hfp) && (h < ha + hfp + hs));
        vsy = !((v >= va + vfp) && (v < va + vfp + vs));
        vid = (h < ha) && (v < va);
        win = (h < ww) && (v < wh) && (adv != 0);
        model = {10'(h), 10'(v), hsy, vsy, vid, pix, fs, win, 19'(addr)};
    endfunction

    function automatic logic [44:0] modelD(input int edges);
        modelD = model(edges, 640, 16, 96, 48, 480, 10, 2, 33, 480, 320);
    endfunction

    function automatic logic [44:0] modelS(input int edges);
        modelS = model(edges, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, S_WW, S_WH);
    endfunction

    // Reset values and the two-edge start-up sequence
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        expV = {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 19'd0};
        if (obsD !== expV) begin
            miscompares++;
            $display("[TB] FAIL reset_D got %h want %h", obsD, expV);
        end
        vectors++;
        expV = {10'd31, 10'd18, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 19'd0};
        if (obsS !== expV) begin
            miscompares++;
            $display("[TB] FAIL reset_S got %h want %h", obsS, expV);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        expV = {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 19'd0};
        if (obsD !== expV) begin
            miscompares++;
            $display("[TB] FAIL edge1_D got %h want %h", obsD, expV);
        end
        @(negedge clk);
        vectors++;
        expV = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 19'd0};
        if (obsD !== expV) begin
            miscompares++;
            $display("[TB] FAIL edge2_D got %h want %h", obsD, expV);
        end
        @(negedge clk);
        vectors++;
        expV = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 19'd0};
        if (obsD !== expV) begin
            miscompares++;
            $display("[TB] FAIL edge3_D got %h want %h", obsD, expV);
        end
    endtask

    // Two full 640x480 lines checked cycle by cycle, plus hsync width and
    // the video_on falling point on line 0
    task automatic test_line();
        int hLow;
        int firstBlank;
        hLow = 0;
        firstBlank = -1;
        for (int i = 0; i < 3300; i++) begin
            @(negedge clk);
            vectors++;
            expV = modelD(k);
            if (obsD !== expV) begin
                miscompares++;
                $display("[TB] FAIL line_D k=%0d got %h want %h", k, obsD, expV);
            end
            vectors++;
            expV = modelS(k);
            if (obsS !== expV) begin
                miscompares++;
                $display("[TB] FAIL line_S k=%0d got %h want %h", k, obsS, expV);
            end
            if (vD == 10'd0 && hsD == 1'b0) hLow++;
            if (vD == 10'd0 && voD == 1'b0 && firstBlank < 0) firstBlank = int'(hD);
        end
        vectors++;
        if (hLow !== 192) begin
            miscompares++;
            $display("[TB] FAIL hsync_width got %0d clk want 192", hLow);
        end
        vectors++;
        if (firstBlank !== 640) begin
            miscompares++;
            $display("[TB] FAIL video_off_h got %0d want 640", firstBlank);
        end
    endtask

    // Three small frames; one frame-length window must hold exactly one
    // frame_start pulse and exactly two lines of vsync
    task automatic test_frame();
        int fsCount;
        int vLow;
        fsCount = 0;
        vLow = 0;
        for (int i = 0; i < 3 * S_FRAME_CLK; i++) begin
            @(negedge clk);
            vectors++;
            expV = modelS(k);
            if (obsS !== expV) begin
                miscompares++;
                $display("[TB] FAIL frame_S k=%0d got %h want %h", k, obsS, expV);
            end
            if (i >= S_FRAME_CLK && i < 2 * S_FRAME_CLK) begin
                if (fsS) fsCount++;
                if (!vsS) vLow++;
            end
        end
        vectors++;
        if (fsCount !== 1) begin
            miscompares++;
            $display("[TB] FAIL frame_start_count got %0d want 1", fsCount);
        end
        vectors++;
        if (vLow !== 2 * 32 * 2) begin
            miscompares++;
            $display("[TB] FAIL vsync_width got %0d clk want 128", vLow);
        end
    endtask

    // Window corner addresses on the small raster over one frame
    task automatic test_window();
        int hits;
        hits = 0;
        for (int i = 0; i < S_FRAME_CLK; i++) begin
            @(negedge clk);
            if (hS == 10'd0 && vS == 10'd0) begin
                hits++; vectors++;
                if ({wvS, waS} !== {1'b1, 19'd0}) begin
                    miscompares++;
                    $display("[TB] FAIL win_0_0 got %b/%0d want 1/0", wvS, waS);
                end
            end else if (hS == 10'd13 && vS == 10'd0) begin
                hits++; vectors++;
                if ({wvS, waS} !== {1'b1, 19'd13}) begin
                    miscompares++;
                    $display("[TB] FAIL win_13_0 got %b/%0d want 1/13", wvS, waS);
                end
            end else if (hS == 10'd14 && vS == 10'd0) begin
                hits++; vectors++;
                if ({wvS, waS} !== {1'b0, 19'd13}) begin
                    miscompares++;
                    $display("[TB] FAIL win_14_0 got %b/%0d want 0/13", wvS, waS);
                end
            end else if (hS == 10'd0 && vS == 10'd1) begin
                hits++; vectors++;
                if ({wvS, waS} !== {1'b1, 19'd14}) begin
                    miscompares++;
                    $display("[TB] FAIL win_0_1 got %b/%0d want 1/14", wvS, waS);
                end
            end else if (hS == 10'd13 && vS == 10'd8) begin
                hits++; vectors++;
                if ({wvS, waS} !== {1'b1, 19'd125}) begin
                    miscompares++;
                    $display("[TB] FAIL win_13_8 got %b/%0d want 1/125", wvS, waS);
                end
            end else if (hS == 10'd0 && vS == 10'd9) begin
                hits++; vectors++;
                if ({wvS, waS} !== {1'b0, 19'd125}) begin
                    miscompares++;
                    $display("[TB] FAIL win_0_9 got %b/%0d want 0/125", wvS, waS);
                end
            end else if (hS == 10'd31 && vS == 10'd18) begin
                hits++; vectors++;
                if ({wvS, waS} !== {1'b0, 19'd125}) begin
                    miscompares++;
                    $display("[TB] FAIL win_hold got %b/%0d want 0/125", wvS, waS);
                end
            end
        end
        vectors++;
        if (hits !== 14) begin
            miscompares++;
            $display("[TB] FAIL window_points got %0d want 14", hits);
        end
    endtask

    // Asynchronous resets at random raster points, then restart check
    task automatic test_mid_reset();
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(100, 3000)) @(negedge clk);
            #($urandom_range(1, 3));
            rst_n = 1'b0;
            #1;
            vectors++;
            expV = modelD(0);
            if (obsD !== expV) begin
                miscompares++;
                $display("[TB] FAIL async_rst_D got %h want %h", obsD, expV);
            end
            vectors++;
            expV = modelS(0);
            if (obsS !== expV) begin
                miscompares++;
                $display("[TB] FAIL async_rst_S got %h want %h", obsS, expV);
            end
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                vectors++;
                expV = modelD(k);
                if (obsD !== expV) begin
                    miscompares++;
                    $display("[TB] FAIL restart_D k=%0d got %h want %h", k, obsD, expV);
                end
                vectors++;
                expV = modelS(k);
                if (obsS !== expV) begin
                    miscompares++;
                    $display("[TB] FAIL restart_S k=%0d got %h want %h", k, obsS, expV);
                end
            end
        end
    endtask

    // Simultaneous H/V wrap from the last pixel of the small frame
    task automatic test_wrap();
        bit found;
        found = 1'b0;
        for (int i = 0; i < S_FRAME_CLK + 4 && !found; i++) begin
            @(negedge clk);
            if (hS == 10'd31 && vS == 10'd18 && ptS) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("[TB] FAIL wrap_search got none want (31,18) with tick");
        end else begin
            @(negedge clk);
            expV = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 19'd0};
            if (obsS !== expV) begin
                miscompares++;
                $display("[TB] FAIL wrap_S got %h want %h", obsS, expV);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        test_reset();
        test_line();
        test_frame();
        test_window();
        test_wrap();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
